// File: rtl/dp_ram.sv
// Dual-port RAM: port A byte-masked write plus read, port B read-only; a zeroing sweep runs after every reset.
// Latency: read data and valid appear 1 cycle after the request (2 cycles when OUT_REG=1).
// Backpressure: none; requests are accepted every READY cycle and ignored while busy is high.
module dp_ram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_W     = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_en,
  input  logic [WIDTH/BYTE_W-1:0]   a_we,
  input  logic [ADDR_WIDTH-1:0]     a_addr,
  input  logic [WIDTH-1:0]          a_din,
  output logic [WIDTH-1:0]          a_dout,
  output logic                      a_valid,
  input  logic                      b_en,
  input  logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [WIDTH-1:0]          b_dout,
  output logic                      b_valid,
  output logic                      busy
);

  localparam int NB    = WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Storage array; deliberately has no reset so it maps onto RAM macros.
  logic [WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  w_busy;
  logic                  w_clr_wr;

  logic                  w_a_acc;
  logic                  w_a_wr;
  logic                  w_b_acc;
  logic                  w_b_hit;
  logic [WIDTH-1:0]      w_a_old;
  logic [WIDTH-1:0]      w_b_old;
  logic [WIDTH-1:0]      w_a_merged;
  logic [WIDTH-1:0]      w_a_rd;
  logic [WIDTH-1:0]      w_b_rd;

  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [WIDTH-1:0]      w_wr_dat;
  logic [NB-1:0]         w_wr_lane;

  logic [WIDTH-1:0]      r_a_s1_dat;
  logic                  r_a_s1_vld;
  logic [WIDTH-1:0]      r_b_s1_dat;
  logic                  r_b_s1_vld;

  // Controller next state: sweep clr_cnt up to the last address, then sit in READY.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy        = 1'b0;
    w_clr_wr      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_wr = 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          // Counter parks at the last address instead of wrapping.
          w_state_nxt = ST_READY;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_ONE;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Controller state register; any reset restarts the sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  assign busy    = w_busy;
  assign w_a_acc = a_en & ~w_busy;
  assign w_a_wr  = w_a_acc & (|a_we);
  assign w_b_acc = b_en & ~w_busy;
  assign w_b_hit = w_a_wr & (b_addr == a_addr);

  // Current contents at both addresses and the word port A's write would leave behind.
  always_comb begin
    w_a_old    = r_mem[a_addr];
    w_b_old    = r_mem[b_addr];
    w_a_merged = w_a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) begin
        w_a_merged[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read-during-write selection: old contents, or the merged word when RDW_MODE is set.
  always_comb begin
    w_a_rd = w_a_old;
    w_b_rd = w_b_old;
    if (RDW_MODE != 0) begin
      if (w_a_wr) begin
        w_a_rd = w_a_merged;
      end
      if (w_b_hit) begin
        w_b_rd = w_a_merged;
      end
    end
  end

  // Single write path shared by the clear sweep (all lanes, zero data) and port A.
  always_comb begin
    w_wr_addr = a_addr;
    w_wr_dat  = a_din;
    w_wr_lane = '0;
    if (w_clr_wr) begin
      w_wr_addr = r_clr_cnt;
      w_wr_dat  = '0;
      w_wr_lane = '1;
    end else if (w_a_acc) begin
      w_wr_lane = a_we;
    end
  end

  // Byte-lane memory write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wr_lane[i]) begin
        r_mem[w_wr_addr][i*BYTE_W +: BYTE_W] <= w_wr_dat[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // First read stage: capture read data on accepted requests, hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_s1_dat <= '0;
      r_a_s1_vld <= 1'b0;
      r_b_s1_dat <= '0;
      r_b_s1_vld <= 1'b0;
    end else begin
      r_a_s1_vld <= w_a_acc;
      r_b_s1_vld <= w_b_acc;
      if (w_a_acc) begin
        r_a_s1_dat <= w_a_rd;
      end
      if (w_b_acc) begin
        r_b_s1_dat <= w_b_rd;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] r_a_s2_dat;
      logic             r_a_s2_vld;
      logic [WIDTH-1:0] r_b_s2_dat;
      logic             r_b_s2_vld;

      // Output pipeline stage: forwards stage-1 results one cycle later, holds between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_s2_dat <= '0;
          r_a_s2_vld <= 1'b0;
          r_b_s2_dat <= '0;
          r_b_s2_vld <= 1'b0;
        end else begin
          r_a_s2_vld <= r_a_s1_vld;
          r_b_s2_vld <= r_b_s1_vld;
          if (r_a_s1_vld) begin
            r_a_s2_dat <= r_a_s1_dat;
          end
          if (r_b_s1_vld) begin
            r_b_s2_dat <= r_b_s1_dat;
          end
        end
      end

      assign a_dout  = r_a_s2_dat;
      assign a_valid = r_a_s2_vld;
      assign b_dout  = r_b_s2_dat;
      assign b_valid = r_b_s2_vld;
    end else begin : g_no_out_reg
      assign a_dout  = r_a_s1_dat;
      assign a_valid = r_a_s1_vld;
      assign b_dout  = r_b_s1_dat;
      assign b_valid = r_b_s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram.sv
// Directed bench for dp_ram: reset sweep, writes, byte lanes, collisions, reset restart, streaming.
// Latency: expectations follow LAT derived from OUT_REG.
// Backpressure: none expected; every accepted request must produce exactly one valid pulse.
module tb_dp_ram;

  localparam int RDW_MODE = 0;
  localparam int OUT_REG  = 0;
  localparam int LAT      = (OUT_REG != 0) ? 2 : 1;
  localparam int DEPTH    = 256;

  logic        clk;
  logic        rst_n;
  logic        a_en;
  logic [1:0]  a_we;
  logic [7:0]  a_addr;
  logic [15:0] a_din;
  logic [15:0] a_dout;
  logic        a_valid;
  logic        b_en;
  logic [7:0]  b_addr;
  logic [15:0] b_dout;
  logic        b_valid;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  dp_ram #(
    .WIDTH(16), .ADDR_WIDTH(8), .BYTE_W(8), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Port A access; returns data at the first valid pulse and the cycles it took.
  task automatic a_access(input logic [7:0] addr, input logic [1:0] we, input logic [15:0] din,
                          output logic [15:0] dat, output int lat);
    a_en = 1'b1; a_we = we; a_addr = addr; a_din = din;
    tick();
    a_en = 1'b0; a_we = 2'b00;
    lat = 1;
    while (a_valid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    dat = a_dout;
  endtask

  task automatic b_read(input logic [7:0] addr, output logic [15:0] dat, output int lat);
    b_en = 1'b1; b_addr = addr;
    tick();
    b_en = 1'b0;
    lat = 1;
    while (b_valid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    dat = b_dout;
  endtask

  // Counts cycles with busy high (sampled before each edge), flags any valid seen meanwhile.
  task automatic wait_sweep(output int cyc, output logic any_av, output logic any_bv);
    cyc = 0; any_av = 1'b0; any_bv = 1'b0;
    while (busy === 1'b1 && cyc < 1000) begin
      if (a_valid !== 1'b0) any_av = 1'b1;
      if (b_valid !== 1'b0) any_bv = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int          lat, cyc;
    logic        av, bv;
    a_en = 0; a_we = 0; a_addr = 0; a_din = 0; b_en = 0; b_addr = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #2;
    n_chk++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
    n_chk++; if (a_valid !== 1'b0) $display("FAIL rst_a_valid: got %b want 0", a_valid); else n_pass++;
    n_chk++; if (b_valid !== 1'b0) $display("FAIL rst_b_valid: got %b want 0", b_valid); else n_pass++;
    n_chk++; if (a_dout !== 16'h0000) $display("FAIL rst_a_dout: got %h want 0000", a_dout); else n_pass++;
    n_chk++; if (b_dout !== 16'h0000) $display("FAIL rst_b_dout: got %h want 0000", b_dout); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    // Requests during the sweep must be ignored: B reads, A hammers 0x80 with 0xFFFF.
    b_en = 1'b1; b_addr = 8'h00;
    a_en = 1'b1; a_we = 2'b11; a_addr = 8'h80; a_din = 16'hFFFF;
    wait_sweep(cyc, av, bv);
    n_chk++; if (cyc !== DEPTH) $display("FAIL sweep_len: got %0d cycles want %0d", cyc, DEPTH); else n_pass++;
    n_chk++; if (bv !== 1'b0) $display("FAIL sweep_b_valid: got %b want 0", bv); else n_pass++;
    n_chk++; if (av !== 1'b0) $display("FAIL sweep_a_valid: got %b want 0", av); else n_pass++;
    n_chk++; if (b_valid !== 1'b0) $display("FAIL sweep_last_b_valid: got %b want 0", b_valid); else n_pass++;
    a_en = 1'b0; a_we = 2'b00; b_en = 1'b0;
    // First read lands on the first READY cycle.
    b_read(8'h00, d, lat);
    n_chk++; if (d !== 16'h0000) $display("FAIL clr_rd_00: got %h want 0000", d); else n_pass++;
    n_chk++; if (lat !== LAT) $display("FAIL clr_lat_00: got %0d want %0d", lat, LAT); else n_pass++;
    b_read(8'h80, d, lat);
    n_chk++; if (d !== 16'h0000) $display("FAIL clr_rd_80: got %h want 0000", d); else n_pass++;
    b_read(8'hFF, d, lat);
    n_chk++; if (d !== 16'h0000) $display("FAIL clr_rd_ff: got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    int          lat;
    a_access(8'h10, 2'b11, 16'hBEEF, d, lat);
    n_chk++; if (lat !== LAT) $display("FAIL wr_a_lat: got %0d want %0d", lat, LAT); else n_pass++;
    b_read(8'h10, d, lat);
    n_chk++; if (d !== 16'hBEEF) $display("FAIL wr_b_data: got %h want beef", d); else n_pass++;
    n_chk++; if (lat !== LAT) $display("FAIL wr_b_lat: got %0d want %0d", lat, LAT); else n_pass++;
    tick();
    n_chk++; if (b_valid !== 1'b0) $display("FAIL wr_b_pulse: got %b want 0", b_valid); else n_pass++;
    n_chk++; if (b_dout !== 16'hBEEF) $display("FAIL wr_b_hold: got %h want beef", b_dout); else n_pass++;
  endtask

  task automatic test_byte_en();
    logic [15:0] d;
    int          lat;
    a_access(8'h20, 2'b11, 16'h1234, d, lat);
    a_access(8'h20, 2'b01, 16'hABCD, d, lat);
    b_read(8'h20, d, lat);
    n_chk++; if (d !== 16'h12CD) $display("FAIL be_lo_b: got %h want 12cd", d); else n_pass++;
    a_access(8'h20, 2'b00, 16'h0000, d, lat);
    n_chk++; if (d !== 16'h12CD) $display("FAIL be_lo_a: got %h want 12cd", d); else n_pass++;
    a_access(8'h20, 2'b10, 16'h9876, d, lat);
    b_read(8'h20, d, lat);
    n_chk++; if (d !== 16'h98CD) $display("FAIL be_hi_b: got %h want 98cd", d); else n_pass++;
  endtask

  task automatic test_collision();
    logic [15:0] d, exp;
    int          lat;
    exp = (RDW_MODE != 0) ? 16'h2222 : 16'h1111;
    a_access(8'h30, 2'b11, 16'h1111, d, lat);
    a_en = 1'b1; a_we = 2'b11; a_addr = 8'h30; a_din = 16'h2222;
    b_en = 1'b1; b_addr = 8'h30;
    tick();
    a_en = 1'b0; a_we = 2'b00; b_en = 1'b0;
    lat = 1;
    while (b_valid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    n_chk++; if (lat !== LAT) $display("FAIL col_lat: got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (a_valid !== 1'b1) $display("FAIL col_a_valid: got %b want 1", a_valid); else n_pass++;
    n_chk++; if (b_dout !== exp) $display("FAIL col_b_dout: got %h want %h", b_dout, exp); else n_pass++;
    n_chk++; if (a_dout !== exp) $display("FAIL col_a_dout: got %h want %h", a_dout, exp); else n_pass++;
    b_read(8'h30, d, lat);
    n_chk++; if (d !== 16'h2222) $display("FAIL col_after: got %h want 2222", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int          lat, cyc;
    logic        av, bv;
    a_access(8'h05, 2'b11, 16'h0055, d, lat);
    b_read(8'h05, d, lat);
    n_chk++; if (d !== 16'h0055) $display("FAIL mid_pre: got %h want 0055", d); else n_pass++;
    // Reset while a read is in flight: nothing from it may survive.
    b_en = 1'b1; b_addr = 8'h05;
    a_en = 1'b1; a_we = 2'b00; a_addr = 8'h05;
    tick();
    b_en = 1'b0; a_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (b_valid !== 1'b0) $display("FAIL mid_flush_bv: got %b want 0", b_valid); else n_pass++;
    n_chk++; if (a_valid !== 1'b0) $display("FAIL mid_flush_av: got %b want 0", a_valid); else n_pass++;
    n_chk++; if (b_dout !== 16'h0000) $display("FAIL mid_flush_bd: got %h want 0000", b_dout); else n_pass++;
    n_chk++; if (a_dout !== 16'h0000) $display("FAIL mid_flush_ad: got %h want 0000", a_dout); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy100: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_sweep(cyc, av, bv);
    n_chk++; if (cyc !== DEPTH) $display("FAIL mid_sweep_len: got %0d cycles want %0d", cyc, DEPTH); else n_pass++;
    n_chk++; if ((av | bv) !== 1'b0) $display("FAIL mid_sweep_valid: got %b want 0", av | bv); else n_pass++;
    b_read(8'h05, d, lat);
    n_chk++; if (d !== 16'h0000) $display("FAIL mid_addr5: got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int          lat, nv;
    logic        exp_v;
    for (int i = 0; i < 16; i++) begin
      a_access(i[7:0], 2'b11, 16'(i), d, lat);
    end
    nv = 0;
    for (int s = 0; s < 16 + LAT + 1; s++) begin
      if (s < 16) begin
        b_en = 1'b1; b_addr = s[7:0];
      end else begin
        b_en = 1'b0;
      end
      tick();
      exp_v = (s >= LAT - 1) && (s < LAT + 15);
      n_chk++;
      if (b_valid !== exp_v) $display("FAIL stream_valid[%0d]: got %b want %b", s, b_valid, exp_v);
      else n_pass++;
      if (b_valid === 1'b1) begin
        nv++;
        n_chk++;
        if (b_dout !== 16'(s - (LAT - 1)))
          $display("FAIL stream_data[%0d]: got %h want %h", s, b_dout, 16'(s - (LAT - 1)));
        else n_pass++;
      end
    end
    n_chk++; if (nv !== 16) $display("FAIL stream_count: got %0d want 16", nv); else n_pass++;
    n_chk++; if (b_dout !== 16'h000F) $display("FAIL stream_hold: got %h want 000f", b_dout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_ram.md
DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter BYTE_W, default 8: byte-lane width; NB = WIDTH/BYTE_W lanes.
REQ-004 Parameter RDW_MODE, default 0: read-during-write result; 0 = old data, 1 = new (merged) data.
REQ-005 Parameter OUT_REG, default 0: 1 adds an output pipeline register to both read ports.
REQ-006 The design SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-007 Port list SHALL be:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_en  in  1  port A access request
- a_we  in  NB  port A byte write enables, any bit set = write
- a_addr  in  ADDR_WIDTH  port A address
- a_din  in  WIDTH  port A write data
- a_dout  out  WIDTH  port A read data
- a_valid  out  1  a_dout updated this cycle
- b_en  in  1  port B read request
- b_addr  in  ADDR_WIDTH  port B address
- b_dout  out  WIDTH  port B read data
- b_valid  out  1  b_dout updated this cycle
- busy  out  1  clear sweep in progress; requests ignored

Function
REQ-008 The controller SHALL have two states, CLEAR and READY.
REQ-009 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1.
REQ-010 After the write to DEPTH-1, the controller SHALL go to READY; busy SHALL be 1 throughout CLEAR and 0 from the first READY cycle.
REQ-011 While busy=1, a_en and b_en SHALL be ignored: no write, and no valid pulse.
REQ-012 In READY with a_en=1, each lane i with a_we[i]=1 SHALL write a_din lane i to mem[a_addr]; lanes with a_we[i]=0 SHALL be unchanged.
REQ-013 In READY with a_en=1, port A SHALL return mem[a_addr] on a_dout regardless of a_we.
REQ-014 In READY with b_en=1, port B SHALL return mem[b_addr] on b_dout; port B never writes.
REQ-015 Read latency SHALL be 1 cycle when OUT_REG=0 and 2 cycles when OUT_REG=1.
- Measured from the request edge to the data/valid edge.
- a_valid/b_valid SHALL be single-cycle pulses aligned with the data.
REQ-016 a_dout and b_dout SHALL hold their last value when no read completes.
REQ-017 A port A write plus a read of the same address in the same cycle (port A itself, or port B with b_addr==a_addr) SHALL return:
- pre-write data when RDW_MODE=0;
- post-write merged word when RDW_MODE=1.
REQ-018 Accesses SHALL be accepted every cycle with no back-pressure; back-to-back requests SHALL yield back-to-back valid pulses.
REQ-019 Address arithmetic SHALL be ADDR_WIDTH bits wide, and clr_cnt SHALL NOT wrap past DEPTH-1.

Reset
REQ-020 On rst_n=0, the block SHALL asynchronously:
- enter CLEAR with clr_cnt=0 and busy=1;
- set a_dout=0, b_dout=0, a_valid=0, b_valid=0;
- flush any in-flight reads in pipeline stages, with no valid issued for them.
REQ-021 Reset asserted mid-sweep or mid-access SHALL restart the sweep at address 0.
REQ-022 Memory contents are not reset directly; they SHALL be zero only after the sweep completes.
REQ-023 The first access SHALL be accepted on the cycle busy is first 0, i.e. DEPTH cycles after the first clock edge with rst_n=1.

Verification
REQ-024 The bench SHALL cover these directed scenarios (defaults unless stated):
- Release reset, hold b_en=1 -> busy high for exactly 256 cycles, no b_valid while busy; afterwards reads of addr 0, 0x80, 0xFF return 0x0000.
- A write 0xBEEF to 0x10 with a_we=2'b11, then B read 0x10 -> b_dout=0xBEEF, b_valid exactly 1 cycle after the request (2 when OUT_REG=1).
- Byte enables: mem[0x20]=0x1234, then A write 0xABCD with a_we=2'b01 -> read gives 0x12CD.
- Collision: mem[0x30]=0x1111, A writes 0x2222 while B reads 0x30 same cycle -> b_dout=0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1); a_dout behaves the same.
- Reset asserted at sweep cycle 100 after 0x55 was written to addr 5 by a prior run -> sweep restarts at 0; busy lasts a full 256 cycles after release; addr 5 reads 0.
- Streaming: 16 consecutive B reads of addresses 0..15 preloaded with value=addr -> 16 consecutive b_valid pulses with data 0..15 in order.
